// File: rtl/eth_pkg.sv
// Shared Ethernet ingress types: the 66-bit FIFO word {eop, sop, data}
// and the state encoding of the ingress arbiter.
package eth_pkg;

  typedef logic [65:0] eth_word_t;

  localparam int SOP_BIT = 64;
  localparam int EOP_BIT = 65;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GNT_A   = 3'd1,
    GNT_B   = 3'd2,
    DRAIN_A = 3'd3,
    DRAIN_B = 3'd4
  } arb_state_t;

endpackage

// File: rtl/eth_ingress_arb_if.sv
// Request/ready handshakes from the two receive FSMs plus the FIFO write side.
// The master side is upstream (requesters and FIFO status). The slave side is the arbiter.
interface eth_ingress_arb_if;
  import eth_pkg::*;

  logic      reqVldA;
  eth_word_t reqDataA;
  logic      reqRdyA;
  logic      reqVldB;
  eth_word_t reqDataB;
  logic      reqRdyB;
  logic      fifoAfull;
  logic      outWrEn;
  eth_word_t outData;

  modport master (
    output reqVldA, reqDataA, reqVldB, reqDataB, fifoAfull,
    input  reqRdyA, reqRdyB, outWrEn, outData
  );

  modport slave (
    input  reqVldA, reqDataA, reqVldB, reqDataB, fifoAfull,
    output reqRdyA, reqRdyB, outWrEn, outData
  );

endinterface

// File: rtl/eth_rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins, and on contention
// the port that was not granted last wins.
module eth_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_gnt ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/eth_ingress_arb.sv
// Frame-atomic round-robin arbiter that feeds one ingress FIFO from two receive FSMs.
// It caps frame length at MAX_WORDS and keeps per-port counts of accepted frames and dropped words.
module eth_ingress_arb
  import eth_pkg::*;
#(
  parameter int MAX_WORDS = 32,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             resetN,
  eth_ingress_arb_if.slave bus,
  output logic [CNT_W-1:0] frmCntA,
  output logic [CNT_W-1:0] frmCntB,
  output logic [CNT_W-1:0] dropCntA,
  output logic [CNT_W-1:0] dropCntB
);

  localparam int WC_W = $clog2(MAX_WORDS + 1);

  arb_state_t      state, state_nxt;
  logic            last_gnt, last_gnt_nxt;
  logic [WC_W-1:0] word_cnt, word_cnt_nxt;
  logic            wr_en_nxt, out_wr_en;
  eth_word_t       wr_data_nxt, out_data;
  logic [1:0]      frm_inc, drop_inc;
  logic [1:0]      vld, sop, eop, rdy, acc, cand, gnt;
  eth_word_t       data [2];
  logic            afull, own_b;

  assign data[0] = bus.reqDataA;
  assign data[1] = bus.reqDataB;
  assign vld     = {bus.reqVldB, bus.reqVldA};
  assign sop     = {bus.reqDataB[SOP_BIT], bus.reqDataA[SOP_BIT]};
  assign eop     = {bus.reqDataB[EOP_BIT], bus.reqDataA[EOP_BIT]};
  assign afull   = bus.fifoAfull;
  assign cand    = vld & sop;
  assign own_b   = (state == GNT_B) || (state == DRAIN_B);

  eth_rr_pick2 u_pick (
    .req      (cand),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );

  // Ready is combinational so the SOP is taken in the decision cycle; stray words in IDLE are swallowed
  always_comb begin
    rdy = '0;
    if (resetN) begin
      case (state)
        IDLE: begin
          for (int p = 0; p < 2; p++) begin
            rdy[p] = gnt[p] ? !afull : (vld[p] & !sop[p]);
          end
        end
        GNT_A:   rdy[0] = !afull;
        GNT_B:   rdy[1] = !afull;
        DRAIN_A: rdy[0] = 1'b1;
        DRAIN_B: rdy[1] = 1'b1;
        default: rdy = '0;
      endcase
    end
  end

  assign acc         = vld & rdy;
  assign bus.reqRdyA = rdy[0];
  assign bus.reqRdyB = rdy[1];

  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    word_cnt_nxt = word_cnt;
    wr_en_nxt    = 1'b0;
    wr_data_nxt  = data[own_b];
    frm_inc      = '0;
    drop_inc     = '0;
    case (state)
      IDLE: begin
        for (int p = 0; p < 2; p++) begin
          if (acc[p]) begin
            if (sop[p]) begin
              wr_en_nxt   = 1'b1;
              wr_data_nxt = data[p];
              if (eop[p]) begin
                frm_inc[p]   = 1'b1;
                last_gnt_nxt = (p == 1);
              end else begin
                state_nxt    = (p == 1) ? GNT_B : GNT_A;
                word_cnt_nxt = WC_W'(1);
              end
            end else begin
              drop_inc[p] = 1'b1;
            end
          end
        end
      end
      GNT_A, GNT_B: begin
        if (acc[own_b]) begin
          wr_en_nxt    = 1'b1;
          word_cnt_nxt = word_cnt + WC_W'(1);
          if (eop[own_b]) begin
            state_nxt       = IDLE;
            last_gnt_nxt    = own_b;
            frm_inc[own_b]  = 1'b1;
            word_cnt_nxt    = '0;
          end else if (word_cnt == WC_W'(MAX_WORDS - 1)) begin
            // Terminate the overlength frame in the FIFO and discard its tail
            wr_data_nxt[EOP_BIT] = 1'b1;
            state_nxt            = own_b ? DRAIN_B : DRAIN_A;
          end
        end
      end
      DRAIN_A, DRAIN_B: begin
        if (acc[own_b]) begin
          drop_inc[own_b] = 1'b1;
          if (eop[own_b]) begin
            state_nxt    = IDLE;
            last_gnt_nxt = own_b;
            word_cnt_nxt = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      word_cnt  <= '0;
      out_wr_en <= 1'b0;
      out_data  <= '0;
      frmCntA   <= '0;
      frmCntB   <= '0;
      dropCntA  <= '0;
      dropCntB  <= '0;
    end else begin
      state     <= state_nxt;
      last_gnt  <= last_gnt_nxt;
      word_cnt  <= word_cnt_nxt;
      out_wr_en <= wr_en_nxt;
      out_data  <= wr_en_nxt ? wr_data_nxt : out_data;
      frmCntA   <= frmCntA + CNT_W'(frm_inc[0]);
      frmCntB   <= frmCntB + CNT_W'(frm_inc[1]);
      dropCntA  <= dropCntA + CNT_W'(drop_inc[0]);
      dropCntB  <= dropCntB + CNT_W'(drop_inc[1]);
    end
  end

  assign bus.outWrEn = out_wr_en;
  assign bus.outData = out_data;

endmodule

// File: tb/tb_eth_ingress_arb.sv
// Bench for eth_ingress_arb: a default-length instance and a MAX_WORDS=4 instance share one stimulus stream.
// Both instances are checked every cycle against a frame-level reference model.
module tb_eth_ingress_arb;
  import eth_pkg::*;

  localparam int CNT_W      = 16;
  localparam int MAXW_MAIN  = 32;
  localparam int MAXW_SHORT = 4;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  eth_ingress_arb_if busM ();
  eth_ingress_arb_if busS ();

  logic [CNT_W-1:0] frm_a [2];
  logic [CNT_W-1:0] frm_b [2];
  logic [CNT_W-1:0] drop_a [2];
  logic [CNT_W-1:0] drop_b [2];

  assign busS.reqVldA   = busM.reqVldA;
  assign busS.reqDataA  = busM.reqDataA;
  assign busS.reqVldB   = busM.reqVldB;
  assign busS.reqDataB  = busM.reqDataB;
  assign busS.fifoAfull = busM.fifoAfull;

  eth_ingress_arb #(.MAX_WORDS(MAXW_MAIN), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetN(resetN), .bus(busM),
    .frmCntA(frm_a[0]), .frmCntB(frm_b[0]), .dropCntA(drop_a[0]), .dropCntB(drop_b[0])
  );

  eth_ingress_arb #(.MAX_WORDS(MAXW_SHORT), .CNT_W(CNT_W)) dut_short (
    .clk(clk), .resetN(resetN), .bus(busS),
    .frmCntA(frm_a[1]), .frmCntB(frm_b[1]), .dropCntA(drop_a[1]), .dropCntB(drop_b[1])
  );

  int testsRun    = 0;
  int testsFailed = 0;

  task automatic checkOutput(input string name, input logic [65:0] actual, input logic [65:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic eth_word_t makeWord(input logic eop, input logic sop, input logic [63:0] d);
    return {eop, sop, d};
  endfunction

  function automatic logic inst_wr(input int k);
    return (k == 0) ? busM.outWrEn : busS.outWrEn;
  endfunction

  function automatic eth_word_t inst_data(input int k);
    return (k == 0) ? busM.outData : busS.outData;
  endfunction

  function automatic logic inst_rdy(input int k, input int p);
    if (k == 0) return (p == 0) ? busM.reqRdyA : busM.reqRdyB;
    return (p == 0) ? busS.reqRdyA : busS.reqRdyB;
  endfunction

  // Reference model: who owns the FIFO, whether the owner is being dropped, and the event counts
  int        m_owner [2];
  int        m_count [2];
  int        m_last  [2];
  bit        m_drain [2];
  int        m_frm   [2][2];
  int        m_drop  [2][2];
  logic      m_wr    [2];
  eth_word_t m_data  [2];
  bit        model_acc [2];

  task automatic resetModel(input int k);
    m_owner[k] = -1;
    m_count[k] = 0;
    m_last[k]  = 1;
    m_drain[k] = 0;
    m_wr[k]    = 1'b0;
    m_data[k]  = '0;
    for (int p = 0; p < 2; p++) begin
      m_frm[k][p]  = 0;
      m_drop[k][p] = 0;
    end
  endtask

  task automatic stepModel(input int k);
    logic      v [2];
    eth_word_t w [2];
    logic      exp_rdy [2];
    bit        was_idle;
    int        winner;
    int        max_w;
    max_w = (k == 0) ? MAXW_MAIN : MAXW_SHORT;
    v[0] = busM.reqVldA;  w[0] = busM.reqDataA;
    v[1] = busM.reqVldB;  w[1] = busM.reqDataB;
    exp_rdy[0] = 1'b0;
    exp_rdy[1] = 1'b0;
    was_idle = (m_owner[k] < 0);
    if (was_idle) begin
      bit c0, c1;
      c0 = v[0] && w[0][SOP_BIT];
      c1 = v[1] && w[1][SOP_BIT];
      winner = -1;
      if (c0 && c1)  winner = (m_last[k] == 0) ? 1 : 0;
      else if (c0)   winner = 0;
      else if (c1)   winner = 1;
      for (int p = 0; p < 2; p++)
        exp_rdy[p] = (p == winner) ? !busM.fifoAfull : (v[p] && !w[p][SOP_BIT]);
    end else begin
      exp_rdy[m_owner[k]] = m_drain[k] ? 1'b1 : !busM.fifoAfull;
    end
    for (int p = 0; p < 2; p++)
      checkOutput($sformatf("inst%0d rdy%0d", k, p), inst_rdy(k, p), exp_rdy[p]);
    m_wr[k] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      bit acc;
      acc = v[p] && exp_rdy[p];
      if (k == 0) model_acc[p] = acc;
      if (acc) begin
        if (was_idle) begin
          if (!w[p][SOP_BIT]) begin
            m_drop[k][p]++;
          end else begin
            m_wr[k] = 1'b1;  m_data[k] = w[p];
            if (w[p][EOP_BIT]) begin m_frm[k][p]++; m_last[k] = p; end
            else begin m_owner[k] = p; m_count[k] = 1; end
          end
        end else if (m_drain[k]) begin
          m_drop[k][p]++;
          if (w[p][EOP_BIT]) begin m_owner[k] = -1; m_drain[k] = 0; m_last[k] = p; end
        end else begin
          m_count[k]++;
          m_wr[k] = 1'b1;  m_data[k] = w[p];
          if (w[p][EOP_BIT]) begin
            m_frm[k][p]++;  m_owner[k] = -1;  m_last[k] = p;
          end else if (m_count[k] == max_w) begin
            m_data[k][EOP_BIT] = 1'b1;
            m_drain[k] = 1;
          end
        end
      end
    end
  endtask

  // Registered outputs now reflect the prediction made one negedge earlier
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("inst%0d outWrEn", k), inst_wr(k), m_wr[k]);
      checkOutput($sformatf("inst%0d outData", k), inst_data(k), m_data[k]);
      checkOutput($sformatf("inst%0d frmCntA", k), frm_a[k], 66'(m_frm[k][0] % 65536));
      checkOutput($sformatf("inst%0d frmCntB", k), frm_b[k], 66'(m_frm[k][1] % 65536));
      checkOutput($sformatf("inst%0d dropCntA", k), drop_a[k], 66'(m_drop[k][0] % 65536));
      checkOutput($sformatf("inst%0d dropCntB", k), drop_b[k], 66'(m_drop[k][1] % 65536));
      if (!resetN) begin
        checkOutput($sformatf("inst%0d rdyA in reset", k), inst_rdy(k, 0), 1'b0);
        checkOutput($sformatf("inst%0d rdyB in reset", k), inst_rdy(k, 1), 1'b0);
        resetModel(k);
        model_acc[0] = 0;
        model_acc[1] = 0;
      end else begin
        stepModel(k);
      end
    end
  end

  logic got_rdy_a, got_rdy_b, short_rdy_a;

  task automatic applyStimulus(input logic rst_n, input logic va, input eth_word_t da,
                               input logic vb, input eth_word_t db, input logic af);
    resetN         = rst_n;
    busM.reqVldA   = va;
    busM.reqDataA  = da;
    busM.reqVldB   = vb;
    busM.reqDataB  = db;
    busM.fifoAfull = af;
    @(negedge clk);
    got_rdy_a   = busM.reqRdyA;
    got_rdy_b   = busM.reqRdyB;
    short_rdy_a = busS.reqRdyA;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic      rst_n;
    logic      va;
    eth_word_t da;
    logic      vb;
    eth_word_t db;
    logic      af;
    logic      e_rdy_a;
    logic      e_rdy_b;
    logic      e_wr;
    eth_word_t e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic rst_n, input logic va, input eth_word_t da, input logic vb,
                        input eth_word_t db, input logic era, input logic erb,
                        input logic ewr, input eth_word_t edata);
    vec_t v;
    v = '{rst_n, va, da, vb, db, 1'b0, era, erb, ewr, edata};
    vecs.push_back(v);
  endtask

  int        cur_rem [2];
  logic      cur_v   [2];
  eth_word_t cur_w   [2];

  task automatic pickWord(input int p);
    if (cur_rem[p] == 0) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 30) begin
        cur_v[p] = 1'b0;
      end else if (r < 38) begin
        cur_v[p] = 1'b1;
        cur_w[p] = makeWord(1'($urandom_range(0, 1)), 1'b0, {$urandom, $urandom});
      end else begin
        int len;
        len = ($urandom_range(0, 9) == 0) ? $urandom_range(30, 36) : $urandom_range(1, 8);
        cur_v[p]   = 1'b1;
        cur_w[p]   = makeWord(len == 1, 1'b1, {$urandom, $urandom});
        cur_rem[p] = len - 1;
      end
    end else if ($urandom_range(0, 6) == 0) begin
      cur_v[p] = 1'b0;
    end else begin
      cur_rem[p]--;
      cur_v[p] = 1'b1;
      cur_w[p] = makeWord(cur_rem[p] == 0, 1'b0, {$urandom, $urandom});
    end
  endtask

  initial begin
    eth_word_t a0, a1, a2, a3, c0, c1, c2, d0, d1, z;
    eth_word_t bp [6];
    eth_word_t ov [7];
    eth_word_t e;
    int        k, writes_seen;

    resetModel(0);
    resetModel(1);
    resetN         = 1'b0;
    busM.reqVldA   = 1'b0;
    busM.reqDataA  = '0;
    busM.reqVldB   = 1'b0;
    busM.reqDataB  = '0;
    busM.fifoAfull = 1'b0;
    @(posedge clk);
    #1;

    z  = '0;
    a0 = makeWord(1'b0, 1'b1, 64'h1111_1111_1111_1111);
    a1 = makeWord(1'b0, 1'b0, 64'h2222_2222_2222_2222);
    a2 = makeWord(1'b0, 1'b0, 64'h3333_3333_3333_3333);
    a3 = makeWord(1'b1, 1'b0, 64'h4444_4444_4444_4444);
    c0 = makeWord(1'b0, 1'b1, 64'hA1A1_0000_0000_0001);
    c1 = makeWord(1'b1, 1'b0, 64'hA2A2_0000_0000_0002);
    c2 = makeWord(1'b1, 1'b1, 64'hA3A3_0000_0000_0003);
    d0 = makeWord(1'b0, 1'b1, 64'hB1B1_0000_0000_0001);
    d1 = makeWord(1'b1, 1'b0, 64'hB2B2_0000_0000_0002);

    // A-only frame, then reset, then contention where A wins first and B wins the next round
    addVec(1, 1, a0, 0, z,  1, 0, 1, a0);
    addVec(1, 1, a1, 0, z,  1, 0, 1, a1);
    addVec(1, 1, a2, 0, z,  1, 0, 1, a2);
    addVec(1, 1, a3, 0, z,  1, 0, 1, a3);
    addVec(1, 0, z,  0, z,  0, 0, 0, a3);
    addVec(0, 0, z,  0, z,  0, 0, 0, z);
    addVec(1, 1, c0, 1, d0, 1, 0, 1, c0);
    addVec(1, 1, c1, 1, d0, 1, 0, 1, c1);
    addVec(1, 1, c2, 1, d0, 0, 1, 1, d0);
    addVec(1, 1, c2, 1, d1, 0, 1, 1, d1);
    addVec(1, 1, c2, 0, z,  1, 0, 1, c2);
    addVec(1, 0, z,  0, z,  0, 0, 0, c2);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst_n, vecs[i].va, vecs[i].da, vecs[i].vb, vecs[i].db, vecs[i].af);
      checkOutput($sformatf("vec%0d rdyA", i), got_rdy_a, vecs[i].e_rdy_a);
      checkOutput($sformatf("vec%0d rdyB", i), got_rdy_b, vecs[i].e_rdy_b);
      checkOutput($sformatf("vec%0d outWrEn", i), busM.outWrEn, vecs[i].e_wr);
      checkOutput($sformatf("vec%0d outData", i), busM.outData, vecs[i].e_data);
    end
    checkOutput("contention frmCntA", frm_a[0], 66'd2);
    checkOutput("contention frmCntB", frm_b[0], 66'd1);

    // Backpressure: afull held for three cycles while A holds word 2 of a 6-word frame
    applyStimulus(0, 0, z, 0, z, 0);
    for (int i = 0; i < 6; i++)
      bp[i] = makeWord(i == 5, i == 0, 64'h6000_0000_0000_0000 + 64'(i));
    k = 0;
    writes_seen = 0;
    for (int cyc = 0; cyc < 20 && k < 6; cyc++) begin
      logic af;
      af = (cyc >= 2 && cyc <= 4);
      applyStimulus(1, 1, bp[k], 0, z, af);
      if (busM.outWrEn) writes_seen++;
      checkOutput($sformatf("bp cyc%0d rdyA", cyc), got_rdy_a, !af);
      if (af) begin
        checkOutput($sformatf("bp cyc%0d stalled outWrEn", cyc), busM.outWrEn, 1'b0);
      end else begin
        checkOutput($sformatf("bp word%0d outData", k), busM.outData, bp[k]);
        k++;
      end
    end
    applyStimulus(1, 0, z, 0, z, 0);
    checkOutput("bp writes delivered", writes_seen, 66'd6);
    checkOutput("bp frmCntA", frm_a[0], 66'd1);

    // Overlength frame on the MAX_WORDS=4 instance: four written, fourth forced to EOP, three dropped
    applyStimulus(0, 0, z, 0, z, 0);
    for (int i = 0; i < 7; i++) begin
      ov[i] = makeWord(i == 6, i == 0, 64'h7000_0000_0000_0000 + 64'(i));
      applyStimulus(1, 1, ov[i], 0, z, 0);
      checkOutput($sformatf("ovl word%0d rdyA", i), short_rdy_a, 1'b1);
      checkOutput($sformatf("ovl word%0d outWrEn", i), busS.outWrEn, i < 4);
      if (i < 4) begin
        e = ov[i];
        if (i == 3) e[EOP_BIT] = 1'b1;
        checkOutput($sformatf("ovl word%0d outData", i), busS.outData, e);
      end
    end
    applyStimulus(1, 0, z, 0, z, 0);
    checkOutput("ovl dropCntA", drop_a[1], 66'd3);
    checkOutput("ovl frmCntA", frm_a[1], 66'd0);
    checkOutput("ovl main frmCntA", frm_a[0], 66'd1);

    // Stray non-SOP word on B, then a single-word frame
    applyStimulus(0, 0, z, 0, z, 0);
    applyStimulus(1, 0, z, 1, makeWord(1'b0, 1'b0, 64'h5555_5555_5555_5555), 0);
    checkOutput("stray rdyB", got_rdy_b, 1'b1);
    checkOutput("stray outWrEn", busM.outWrEn, 1'b0);
    e = makeWord(1'b1, 1'b1, 64'h6666_6666_6666_6666);
    applyStimulus(1, 0, z, 1, e, 0);
    checkOutput("single rdyB", got_rdy_b, 1'b1);
    checkOutput("single outData", busM.outData, e);
    applyStimulus(1, 0, z, 0, z, 0);
    checkOutput("single dropCntB", drop_b[0], 66'd1);
    checkOutput("single frmCntB", frm_b[0], 66'd1);

    // Reset during word 2 of an A frame, then a fresh frame
    applyStimulus(1, 1, makeWord(1'b0, 1'b1, 64'h8000_0000_0000_0001), 0, z, 0);
    checkOutput("rst pre-frame rdyA", got_rdy_a, 1'b1);
    applyStimulus(0, 1, makeWord(1'b0, 1'b0, 64'h8000_0000_0000_0002), 0, z, 0);
    checkOutput("rst rdyA low", got_rdy_a, 1'b0);
    checkOutput("rst outWrEn", busM.outWrEn, 1'b0);
    checkOutput("rst outData", busM.outData, 66'd0);
    checkOutput("rst frmCntB", frm_b[0], 66'd0);
    checkOutput("rst dropCntB", drop_b[0], 66'd0);
    e = makeWord(1'b0, 1'b1, 64'h8000_0000_0000_0003);
    applyStimulus(1, 1, e, 0, z, 0);
    checkOutput("post-rst rdyA", got_rdy_a, 1'b1);
    checkOutput("post-rst outData", busM.outData, e);
    applyStimulus(1, 1, makeWord(1'b1, 1'b0, 64'h8000_0000_0000_0004), 0, z, 0);
    applyStimulus(1, 0, z, 0, z, 0);
    checkOutput("post-rst frmCntA", frm_a[0], 66'd1);

    // Randomized traffic: sources honour the handshake as predicted by the model for the main instance
    for (int p = 0; p < 2; p++) begin
      cur_rem[p] = 0;
      cur_v[p]   = 1'b0;
      cur_w[p]   = '0;
    end
    for (int cyc = 0; cyc < 2500; cyc++) begin
      for (int p = 0; p < 2; p++)
        if (!cur_v[p] || model_acc[p]) pickWord(p);
      applyStimulus($urandom_range(0, 399) != 0, cur_v[0], cur_w[0], cur_v[1], cur_w[1],
                    $urandom_range(0, 4) == 0);
    end
    applyStimulus(1, 0, z, 0, z, 0);
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
